// File: rtl/id_stream_arbiter.sv
// Round-robin arbiter framing two character streams onto one shared, reset-less
// identifier recognizer; returns one verdict per string and counts matches.
module id_stream_arbiter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [7:0]       req0_char,
    input  logic             req0_last,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [7:0]       req1_char,
    input  logic             req1_last,
    output logic             req1_ready,
    output logic [7:0]       rec_char,
    input  logic             rec_out,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic             rsp_match,
    output logic             rsp_err,
    output logic [CNT_W-1:0] match_cnt0,
    output logic [CNT_W-1:0] match_cnt1
);

    typedef enum logic [1:0] {
        StIdle,
        StXfer,
        StResult
    } state_t;

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    state_t     state_q;
    logic       grant_q;
    logic       last_served_q;

    logic       gnt_valid;
    logic       gnt_last;
    logic [7:0] gnt_char;
    logic       sel;

    assign gnt_valid = grant_q ? req1_valid : req0_valid;
    assign gnt_last  = grant_q ? req1_last  : req0_last;
    assign gnt_char  = grant_q ? req1_char  : req0_char;

    // On contention the requester not served last wins; otherwise the lone requester.
    assign sel = (req0_valid && req1_valid) ? ~last_served_q : req1_valid;

    // Anything other than a live character is 8'h00, which flushes the recognizer.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rec_char   = 8'h00;
        if (state_q == StXfer) begin
            req0_ready = ~grant_q & req0_valid;
            req1_ready = grant_q & req1_valid;
            rec_char   = gnt_valid ? gnt_char : 8'h00;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            grant_q       <= 1'b0;
            last_served_q <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_id        <= 1'b0;
            rsp_match     <= 1'b0;
            rsp_err       <= 1'b0;
            match_cnt0    <= '0;
            match_cnt1    <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req0_valid || req1_valid) begin
                        grant_q <= sel;
                        state_q <= StXfer;
                    end
                end
                StXfer: begin
                    if (gnt_valid) begin
                        if (gnt_last) begin
                            last_served_q <= grant_q;
                            state_q       <= StResult;
                        end
                    end else begin
                        // A stall cannot be held in the recognizer: abort the string.
                        rsp_valid     <= 1'b1;
                        rsp_err       <= 1'b1;
                        rsp_match     <= 1'b0;
                        rsp_id        <= grant_q;
                        last_served_q <= grant_q;
                        state_q       <= StIdle;
                    end
                end
                StResult: begin
                    rsp_valid <= 1'b1;
                    rsp_match <= rec_out;
                    rsp_err   <= 1'b0;
                    rsp_id    <= grant_q;
                    state_q   <= StIdle;
                    if (rec_out) begin
                        if (!grant_q && match_cnt0 != CntMax) begin
                            match_cnt0 <= match_cnt0 + CntOne;
                        end
                        if (grant_q && match_cnt1 != CntMax) begin
                            match_cnt1 <= match_cnt1 + CntOne;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/id_stream_arbiter.md
# id_stream_arbiter

Arbitrates two character-stream requesters onto the team's single shared identifier recognizer, the `id_fsm`-style block with an 8-bit char input and a 1-bit out. The recognizer has no reset or enable and consumes `rec_char` on every clock. This block therefore frames each string, flushes the recognizer with an illegal character between strings, and samples the recognizer's verdict after each string's last character. It returns one response per string and keeps saturating per-requester match counters.

## Interface
- `CNT_W`, 8, width of each per-requester match counter
- `clk` in 1: sole clock, rising edge
- `reset` in 1: asynchronous, active-high
- `req0_valid` in 1: requester 0 has a character
- `req0_char` in 8: requester 0 character
- `req0_last` in 1: current character ends requester 0's string
- `req0_ready` out 1: requester 0 character accepted this cycle
- `req1_valid`, `req1_char`, `req1_last`, `req1_ready`: same as requester 0, for requester 1
- `rec_char` out 8: character driven to the shared recognizer
- `rec_out` in 1: recognizer output, 1 when its state is Digit (letter-run followed by digit-run)
- `rsp_valid` out 1: one-cycle response pulse
- `rsp_id` out 1: requester that owned the string
- `rsp_match` out 1: string classified as identifier
- `rsp_err` out 1: string aborted by protocol error
- `match_cnt0` out CNT_W: saturating count of matches for requester 0
- `match_cnt1` out CNT_W: saturating count of matches for requester 1

## Operation
- States are IDLE, XFER and RESULT; the reset state is IDLE.
- Registers `grant` (1 bit) and `last_served` (1 bit) are kept internally. `last_served` resets to 1, so requester 0 wins first.
- **IDLE**
  - `rec_char` = 8'h00, which flushes the recognizer to Illegal. Both ready outputs are 0.
  - If exactly one valid is high, that requester is selected. If both are high, the requester ≠ `last_served` is selected.
  - At the clock edge: `grant` <= selected requester, state <= XFER.
- **XFER**
  - The granted requester's ready = `req_valid[grant]`; the other ready = 0.
  - `rec_char` = `req_char[grant]` when valid, else 8'h00.
  - Handshake with last = 1: state <= RESULT and `last_served` <= `grant`.
  - Handshake with last = 0: stay in XFER.
  - Valid = 0 in XFER (stall inside a string) is a protocol error, because the recognizer cannot be held. At the edge: `rsp_valid`<=1, `rsp_err`<=1, `rsp_match`<=0, `rsp_id`<=`grant`, `last_served`<=`grant`, state<=IDLE. The 8'h00 driven that cycle flushes the recognizer.
- **RESULT**
  - `rec_char` = 8'h00. `rec_out` reflects the string's final character.
  - At the edge: `rsp_valid`<=1, `rsp_match`<=`rec_out`, `rsp_err`<=0, `rsp_id`<=`grant`, state<=IDLE.
  - If `rec_out` = 1, `match_cnt[grant]` increments, saturating at 2^CNT_W−1.
- The non-granted requester is never readied; it holds its valid until granted.
- A string must be at least 1 character; `last` on the first character is legal.

## Timing
- Reset values: `rec_char` = 0, all readies = 0, `rsp_valid`/`rsp_id`/`rsp_match`/`rsp_err` = 0, counters = 0, state IDLE. The recognizer is flushed by the 8'h00 driven during reset.
- `rsp_*` are registered. `rsp_valid` is high exactly one cycle; `rsp_id`/`rsp_match`/`rsp_err` hold until the next response.
- `rec_char` and ready outputs are combinational from state, `grant` and the granted valid/char.
- An N-character string uses one IDLE grant cycle, N XFER cycles and one RESULT cycle. `rsp_valid` is high in the cycle after RESULT, which is also the next IDLE arbitration cycle. Back-to-back throughput is therefore one string per N+2 cycles.
- Simultaneous valid on both requesters in IDLE: round-robin as above; there is no starvation.
- `reset` asserted mid-string: immediate return to IDLE. No response is issued for the interrupted string, counters clear, and `last_served` = 1.

## Test plan
- Req0 sends "a1" (8'h61, 8'h31 with last): grant at cycle 1, XFER cycles 2–3, RESULT cycle 4; then `rsp_valid` = 1, `rsp_id` = 0, `rsp_match` = 1, `rsp_err` = 0, and `match_cnt0` = 1.
- Req1 sends "1a" and then "ab": both give `rsp_match` = 0, `rsp_id` = 1, and `match_cnt1` stays 0. The "ab" response shows the flush between strings.
- Both requesters hold "x9" from reset: req0 is served first, then req1, then req0. Responses alternate `rsp_id` 0, 1, 0, spaced 4 cycles apart. `rec_char` = 0 in every IDLE and RESULT cycle.
- Req0 sends "a", drops valid for one cycle, then sends "1" with last: an error response (`rsp_err` = 1, `rsp_match` = 0) follows the drop. The "1" is then treated as a new string and gives `rsp_match` = 0.
- With `CNT_W` = 2, req0 sends "z5" five times: `match_cnt0` reads 1, 2, 3, 3, 3.
- Reset is asserted during the second character of "q7": outputs clear asynchronously and no response pulses. After release, a new "q7" gives `rsp_match` = 1.
